// File: rtl/gs232c_jhr_pkg.sv
// Shared widths and types for the indirect-jump history register.
package gs232c_jhr_pkg;

  localparam int unsigned GS232C_TGT_W      = 30;
  localparam int unsigned GS232C_JHR_PATH_W = 64;
  localparam int unsigned GS232C_JHR_FOLD_W = 4;

  // Source of the next bt-level path history, in priority order BR > PR > ADV > HOLD.
  typedef enum logic [1:0] {
    BT_HOLD,
    BT_ADV,
    BT_FROM_PR,
    BT_FROM_BR
  } bt_src_e;

endpackage

// File: rtl/gs232c_jhr_if.sv
// Pipeline-event inputs and history outputs of gs232c_jhr, grouped as one bundle.
interface gs232c_jhr_if
  import gs232c_jhr_pkg::*;
#(
  parameter int unsigned TGT_W  = GS232C_TGT_W,
  parameter int unsigned PATH_W = GS232C_JHR_PATH_W
);

  logic              pc_go;
  logic              bt_jrop;
  logic [TGT_W-1:0]  bt_target;
  logic              pr_go;
  logic              pr_jrop;
  logic [TGT_W-1:0]  pr_target;
  logic              pr_cancel;
  logic              br_valid;
  logic              br_jrop;
  logic [31:0]       br_target;
  logic              br_cancel;
  logic [TGT_W-1:0]  jhr_last_br;
  logic [TGT_W-1:0]  jhr_last_pr;
  logic [PATH_W-1:0] jhr_path_br;
  logic [PATH_W-1:0] jhr_path_pr;
  logic [PATH_W-1:0] jhr_path_bt;

  modport slave (
    input  pc_go, bt_jrop, bt_target,
    input  pr_go, pr_jrop, pr_target, pr_cancel,
    input  br_valid, br_jrop, br_target, br_cancel,
    output jhr_last_br, jhr_last_pr, jhr_path_br, jhr_path_pr, jhr_path_bt
  );

  modport master (
    output pc_go, bt_jrop, bt_target,
    output pr_go, pr_jrop, pr_target, pr_cancel,
    output br_valid, br_jrop, br_target, br_cancel,
    input  jhr_last_br, jhr_last_pr, jhr_path_br, jhr_path_pr, jhr_path_bt
  );

endinterface

// File: rtl/gs232c_jhr_fold.sv
// XOR-folds a jump target word into FOLD_W bits; the top partial chunk is zero-extended.
module gs232c_jhr_fold
  import gs232c_jhr_pkg::*;
#(
  parameter int unsigned TGT_W  = GS232C_TGT_W,
  parameter int unsigned FOLD_W = GS232C_JHR_FOLD_W
) (
  input  logic [TGT_W-1:0]  i_target,
  output logic [FOLD_W-1:0] o_fold
);

  logic [FOLD_W-1:0] w_fold;

  always_comb begin
    w_fold = '0;
    for (int unsigned i = 0; i < TGT_W; i++) begin
      w_fold[i % FOLD_W] = w_fold[i % FOLD_W] ^ i_target[i];
    end
  end

  assign o_fold = w_fold;

endmodule

// File: rtl/gs232c_jhr.sv
// Jump history register: last indirect-jump target and folded path history at bt, pr and br levels.
module gs232c_jhr
  import gs232c_jhr_pkg::*;
#(
  parameter int unsigned TGT_W  = GS232C_TGT_W,
  parameter int unsigned PATH_W = GS232C_JHR_PATH_W,
  parameter int unsigned FOLD_W = GS232C_JHR_FOLD_W
) (
  input  logic         clock,
  input  logic         resetn,
  gs232c_jhr_if.slave  bus
);

  logic [TGT_W-1:0]  r_last_br, r_last_pr;
  logic [PATH_W-1:0] r_path_br, r_path_pr, r_path_bt;

  logic [FOLD_W-1:0] w_fold_bt, w_fold_pr, w_fold_br;
  logic              w_brv, w_pr_adv;
  logic [TGT_W-1:0]  w_br_tgt;
  logic [TGT_W-1:0]  w_last_br_n, w_last_pr_n;
  logic [PATH_W-1:0] w_path_br_n, w_path_pr_n, w_path_bt_n;
  bt_src_e           w_bt_src;
  logic              w_unused_br_lsb;

  assign w_br_tgt        = bus.br_target[TGT_W+1:2];
  assign w_unused_br_lsb = ^bus.br_target[1:0];

  gs232c_jhr_fold #(.TGT_W(TGT_W), .FOLD_W(FOLD_W)) u_fold_bt (
    .i_target (bus.bt_target),
    .o_fold   (w_fold_bt)
  );

  gs232c_jhr_fold #(.TGT_W(TGT_W), .FOLD_W(FOLD_W)) u_fold_pr (
    .i_target (bus.pr_target),
    .o_fold   (w_fold_pr)
  );

  gs232c_jhr_fold #(.TGT_W(TGT_W), .FOLD_W(FOLD_W)) u_fold_br (
    .i_target (w_br_tgt),
    .o_fold   (w_fold_br)
  );

  // A br_cancel implies its branch has resolved, so it qualifies the update on its own.
  assign w_brv       = (bus.br_valid | bus.br_cancel) & bus.br_jrop;
  assign w_last_br_n = w_brv ? w_br_tgt : r_last_br;
  assign w_path_br_n = w_brv ? {r_path_br[PATH_W-FOLD_W-1:0], w_fold_br} : r_path_br;

  assign w_pr_adv    = bus.pr_go & bus.pr_jrop;
  assign w_last_pr_n = w_pr_adv ? bus.pr_target : r_last_pr;
  assign w_path_pr_n = w_pr_adv ? {r_path_pr[PATH_W-FOLD_W-1:0], w_fold_pr} : r_path_pr;

  always_comb begin
    w_bt_src = BT_HOLD;
    if (bus.br_cancel)                  w_bt_src = BT_FROM_BR;
    else if (bus.pr_cancel)             w_bt_src = BT_FROM_PR;
    else if (bus.pc_go && bus.bt_jrop)  w_bt_src = BT_ADV;
  end

  always_comb begin
    w_path_bt_n = r_path_bt;
    case (w_bt_src)
      BT_FROM_BR: w_path_bt_n = w_path_br_n;
      BT_FROM_PR: w_path_bt_n = w_path_pr_n;
      BT_ADV:     w_path_bt_n = {r_path_bt[PATH_W-FOLD_W-1:0], w_fold_bt};
      default:    w_path_bt_n = r_path_bt;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_br <= '0;
      r_path_br <= '0;
      r_last_pr <= '0;
      r_path_pr <= '0;
      r_path_bt <= '0;
    end else begin
      r_last_br <= w_last_br_n;
      r_path_br <= w_path_br_n;
      if (bus.br_cancel) begin
        r_last_pr <= w_last_br_n;
        r_path_pr <= w_path_br_n;
      end else begin
        r_last_pr <= w_last_pr_n;
        r_path_pr <= w_path_pr_n;
      end
      r_path_bt <= w_path_bt_n;
    end
  end

  assign bus.jhr_last_br = r_last_br;
  assign bus.jhr_last_pr = r_last_pr;
  assign bus.jhr_path_br = r_path_br;
  assign bus.jhr_path_pr = r_path_pr;
  assign bus.jhr_path_bt = r_path_bt;

endmodule
